// File: rtl/instr_fetch.sv
// instr_fetch: program counter and instruction-fetch unit feeding the instruction register.
// Optional fetch-wait timeout is compiled in with `define FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int              BITS           = 32,
  parameter int              JMP_LEFT       = 25,
  parameter int              IMM_LEFT       = 16,
  parameter logic [BITS-1:0] RESET_VECTOR   = 32'h0000_0000,
  parameter logic [BITS-1:0] EXC_VECTOR     = 32'h0000_0080,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_,
  output logic [BITS-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [BITS-1:0]   imem_data,
  output logic              load_instr,
  output logic [BITS-1:0]   mem_data,
  input  logic              jmp,
  input  logic              jal,
  input  logic              jreg,
  input  logic              breq,
  input  logic              brne,
  input  logic              halt,
  input  logic              exception,
  input  logic              equal,
  input  logic              not_equal,
  input  logic [JMP_LEFT:0] addr,
  input  logic [IMM_LEFT-1:0] imm,
  input  logic [BITS-1:0]   jr_data,
  output logic [BITS-1:0]   pc_plus4,
  output logic [BITS-1:0]   epc,
  output logic              halted,
  output logic              bus_err
);

  typedef enum logic [1:0] {RUN = 2'd0, EXC = 2'd1, HALTED = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] pc_q, pc_d;
  logic [BITS-1:0] instr_pc_q, instr_pc_d;
  logic [BITS-1:0] epc_q, epc_d;
  logic            redir_done_q, redir_done_d;

  logic            running, flow_change, redirect, take_exc, timeout;
  logic [BITS-1:0] branch_target, jump_target, jreg_target;

  assign running     = (state_q == RUN);
  assign flow_change = exception | halt | jreg | jmp | jal | (breq & equal) | (brne & not_equal);
  // redir_done keeps a flag held by the decoder from steering the PC twice
  assign redirect    = running & ~redir_done_q & flow_change;
  assign take_exc    = running & ~redir_done_q & exception;

  assign imem_req    = running & rst_;
  assign load_instr  = imem_req & imem_ack & ~redirect;
  assign imem_addr   = pc_q;
  assign mem_data    = imem_data;
  assign pc_plus4    = instr_pc_q + BITS'(4);
  assign epc         = epc_q;
  assign halted      = (state_q == HALTED);

  assign jreg_target   = jr_data & ~BITS'(3);
  assign jump_target   = {pc_plus4[BITS-1:JMP_LEFT+3], addr, 2'b00};
  assign branch_target = pc_plus4 + {{(BITS-IMM_LEFT-2){imm[IMM_LEFT-1]}}, imm, 2'b00};

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_q, wait_d;
  logic          bus_err_q, bus_err_d;

  assign timeout = running & ~imem_ack & (wait_q == CW'(TIMEOUT_CYCLES - 1));
  assign bus_err = bus_err_q;

  always_comb begin
    wait_d    = '0;
    bus_err_d = timeout & ~take_exc;
    if (imem_req & ~imem_ack & ~redirect & ~timeout)
      wait_d = wait_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_pc_d   = instr_pc_q;
    epc_d        = epc_q;
    redir_done_d = redir_done_q;
    case (state_q)
      RUN: begin
        if (take_exc) begin
          epc_d        = instr_pc_q;
          pc_d         = EXC_VECTOR;
          state_d      = EXC;
          redir_done_d = 1'b1;
        end else if (timeout) begin
          epc_d        = pc_q;
          pc_d         = EXC_VECTOR;
          state_d      = EXC;
          redir_done_d = 1'b1;
        end else if (redirect) begin
          redir_done_d = 1'b1;
          if (halt)             state_d = HALTED;
          else if (jreg)        pc_d    = jreg_target;
          else if (jmp | jal)   pc_d    = jump_target;
          else                  pc_d    = branch_target;
        end else if (load_instr) begin
          instr_pc_d   = pc_q;
          pc_d         = pc_q + BITS'(4);
          redir_done_d = 1'b0;
        end
      end
      EXC:     state_d = RUN;
      default: state_d = HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= RUN;
      pc_q         <= RESET_VECTOR;
      instr_pc_q   <= RESET_VECTOR;
      epc_q        <= '0;
      redir_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_pc_q   <= instr_pc_d;
      epc_q        <= epc_d;
      redir_done_q <= redir_done_d;
    end
  end

endmodule
